// File: rtl/conv_pool_pkg.sv
// conv_pool_pkg: FSM state encoding and output/pool dimension helpers for conv_pool_layer
package conv_pool_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DRAIN} state_t;
  function automatic int out_dim(input int in_dim, input int ksize);
    return in_dim - ksize + 1;
  endfunction
  function automatic int pool_dim(input int in_dim, input int ksize);
    return out_dim(in_dim, ksize) / 2;
  endfunction
endpackage

// File: rtl/max4_signed.sv
// max4_signed: combinational signed maximum of four words (a, b, c, d in; y out)
module max4_signed #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] y
);
  logic signed [WIDTH-1:0] ab, cd;
  always_comb begin
    ab = a > b ? a : b;
    cd = c > d ? c : d;
    y  = ab > cd ? ab : cd;
  end
endmodule

// File: rtl/conv_pool_layer.sv
// conv_pool_layer: sequences a conv + 2x2 max-pool layer over an external calc unit.
//   control : clk, rst_n (async, active low), layer_en_i start, busy_o, done_o pulse
//   read    : rd_addr_o window-row address, rd_data_i row words one cycle later
//   calc    : calc_win_o/calc_kidx_o/calc_valid_o issue, calc_res_i back after CALC_LAT
//   write   : wr_en_o/wr_addr_o/wr_data_o pooled results
//   CONV_POOL_RELU_EN defined: negative pooled maxima are written as zero.
module conv_pool_layer
  import conv_pool_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int KSIZE       = 5,
  parameter int IN_DIM      = 14,
  parameter int NUM_KERNELS = 16,
  parameter int CALC_LAT    = 7,
  parameter int AW          = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           layer_en_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [AW-1:0]                  rd_addr_o,
  input  logic [KSIZE*WIDTH-1:0]         rd_data_i,
  output logic [KSIZE*KSIZE*WIDTH-1:0]   calc_win_o,
  output logic [7:0]                     calc_kidx_o,
  output logic                           calc_valid_o,
  input  logic [WIDTH-1:0]               calc_res_i,
  output logic                           wr_en_o,
  output logic [AW-1:0]                  wr_addr_o,
  output logic [WIDTH-1:0]               wr_data_o
);
  localparam int OUT_DIM  = out_dim(IN_DIM, KSIZE);
  localparam int POOL_DIM = pool_dim(IN_DIM, KSIZE);
  localparam int RW       = KSIZE * WIDTH;
  localparam int RBW      = (KSIZE - 1) * RW;
  localparam int NWR      = NUM_KERNELS * POOL_DIM * POOL_DIM;

  if (OUT_DIM % 2 != 0) begin : g_odd_out_dim
    $fatal(1, "conv_pool_layer: OUT_DIM must be even");
  end

  state_t state;
  logic [7:0] k, py, px, r;
  logic dx, dy, rd_vld;
  logic [RBW-1:0] row_buf;
  logic [7:0] nk, npy, npx;
  logic ndx, ndy, last_q, last_x, last_y, last_win;
  logic [AW-1:0] nbase;
  logic [CALC_LAT-1:0] vpipe;
  logic res_vld;
  logic [1:0] qcnt;
  logic [WIDTH-1:0] q0, q1, q2, pooled;
  logic signed [WIDTH-1:0] mx;
  logic [AW-1:0] wr_idx;

  // Next window position: dx fastest, then dy, px, py, k.
  always_comb begin
    ndx      = ~dx;
    last_q   = dx & dy;
    ndy      = dx ? ~dy : dy;
    last_x   = last_q && px == 8'(POOL_DIM - 1);
    npx      = last_q ? (last_x ? 8'd0 : px + 8'd1) : px;
    last_y   = last_x && py == 8'(POOL_DIM - 1);
    npy      = last_x ? (last_y ? 8'd0 : py + 8'd1) : py;
    last_win = last_y && k == 8'(NUM_KERNELS - 1);
    nk       = last_y ? k + 8'd1 : k;
    nbase    = AW'((2 * int'(npy) + int'(ndy)) * IN_DIM + 2 * int'(npx) + int'(ndx));
  end

  // Row data lands one cycle after its address, so the last row arrives during ISSUE
  // and is merged straight from rd_data_i into the issued window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      rd_addr_o    <= '0;
      calc_win_o   <= '0;
      calc_kidx_o  <= '0;
      calc_valid_o <= 1'b0;
      k            <= '0;
      py           <= '0;
      px           <= '0;
      dy           <= 1'b0;
      dx           <= 1'b0;
      r            <= '0;
      rd_vld       <= 1'b0;
      row_buf      <= '0;
    end else begin
      rd_vld       <= state == FETCH;
      calc_valid_o <= 1'b0;
      if (rd_vld) row_buf <= RBW'({row_buf, rd_data_i});
      case (state)
        IDLE: if (layer_en_i) begin
          state     <= FETCH;
          busy_o    <= 1'b1;
          k         <= '0;
          py        <= '0;
          px        <= '0;
          dy        <= 1'b0;
          dx        <= 1'b0;
          r         <= '0;
          rd_addr_o <= '0;
        end
        FETCH: begin
          r         <= r + 8'd1;
          rd_addr_o <= r == 8'(KSIZE - 1) ? rd_addr_o : rd_addr_o + AW'(IN_DIM);
          state     <= r == 8'(KSIZE - 1) ? ISSUE : FETCH;
        end
        ISSUE: begin
          calc_win_o   <= {row_buf, rd_data_i};
          calc_kidx_o  <= k;
          calc_valid_o <= 1'b1;
          k            <= nk;
          py           <= npy;
          px           <= npx;
          dy           <= ndy;
          dx           <= ndx;
          r            <= '0;
          rd_addr_o    <= nbase;
          state        <= last_win ? DRAIN : FETCH;
        end
        DRAIN: if (done_o) begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end else if (wr_en_o && wr_addr_o == AW'(NWR - 1)) begin
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_vld = vpipe[CALC_LAT-1];

  max4_signed #(.WIDTH(WIDTH)) u_max4 (
    .a(q0),
    .b(q1),
    .c(q2),
    .d(calc_res_i),
    .y(mx)
  );

`ifdef CONV_POOL_RELU_EN
  assign pooled = mx[WIDTH-1] ? '0 : mx;
`else
  assign pooled = mx;
`endif

  // Results return in issue order, so writes are sequential and wr_idx is the pooled address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe     <= '0;
      qcnt      <= '0;
      q0        <= '0;
      q1        <= '0;
      q2        <= '0;
      wr_idx    <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      vpipe   <= CALC_LAT'({vpipe, calc_valid_o});
      wr_en_o <= res_vld && qcnt == 2'd3;
      if (state == IDLE && layer_en_i) begin
        qcnt   <= '0;
        wr_idx <= '0;
      end else if (res_vld) begin
        qcnt <= qcnt + 2'd1;
        q0   <= qcnt == 2'd0 ? calc_res_i : q0;
        q1   <= qcnt == 2'd1 ? calc_res_i : q1;
        q2   <= qcnt == 2'd2 ? calc_res_i : q2;
        if (qcnt == 2'd3) begin
          wr_addr_o <= wr_idx;
          wr_data_o <= pooled;
          wr_idx    <= wr_idx + AW'(1);
        end
      end
    end
  end
endmodule
